// File: rtl/cache_fill_ctrl.sv
// Miss handling for a 4-way, 16-set cache.
// Picks a victim, writes it back if dirty, fills the line, and keeps the PLRU state.
module cache_fill_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_req,
  input  logic [31:0]  miss_addr,
  input  logic [3:0]   way_valid,
  input  logic [3:0]   way_dirty,
  input  logic [91:0]  way_tag,
  input  logic [255:0] evict_data,
  input  logic         hit_update,
  input  logic [3:0]   hit_set,
  input  logic [1:0]   hit_way,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  output logic         dfp_write,
  output logic [255:0] dfp_wdata,
  input  logic [255:0] dfp_rdata,
  input  logic         dfp_resp,
  output logic         fill_we,
  output logic [3:0]   fill_set,
  output logic [1:0]   fill_way,
  output logic [22:0]  fill_tag,
  output logic [255:0] fill_data,
  output logic         miss_done,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    EVICT,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [22:0]  tag_q;
  logic [22:0]  vtag_q;
  logic [3:0]   set_q;
  logic [1:0]   way_q;
  logic [255:0] line_q;
  logic [2:0]   plru_q [16];

  logic [22:0]  tags_in [4];
  logic [3:0]   req_set;
  logic [2:0]   req_plru;
  logic [1:0]   victim;
  logic         victim_dirty;
  logic         accept;
  logic         fill_upd;
  logic         hit_ok;
  logic         unused_offset;

  assign unused_offset = ^miss_addr[4:0];

  for (genvar g = 0; g < 4; g++) begin : g_tags
    assign tags_in[g] = way_tag[23*g +: 23];
  end

  assign req_set  = miss_addr[8:5];
  assign req_plru = plru_q[req_set];

  // Bit b0 picks the pair, b1/b2 pick the way inside it.
  function automatic logic [1:0] plru_victim(input logic [2:0] p);
    logic [1:0] w;
    if (!p[0]) w = p[1] ? 2'd1 : 2'd0;
    else       w = p[2] ? 2'd3 : 2'd2;
    return w;
  endfunction

  // Point the tree away from the way just touched.
  function automatic logic [2:0] plru_touch(
    input logic [2:0] p,
    input logic [1:0] w
  );
    logic [2:0] n;
    n = p;
    unique case (w)
      2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  // Victim: first invalid way, else the PLRU choice.
  always_comb begin
    victim = plru_victim(req_plru);
    if (!way_valid[0])      victim = 2'd0;
    else if (!way_valid[1]) victim = 2'd1;
    else if (!way_valid[2]) victim = 2'd2;
    else if (!way_valid[3]) victim = 2'd3;
    victim_dirty = way_valid[victim] & way_dirty[victim];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          accept  = 1'b1;
          state_d = victim_dirty ? EVICT : FILL;
        end
      end
      EVICT:   if (dfp_resp) state_d = FILL;
      FILL:    if (dfp_resp) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    dfp_addr  = '0;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    dfp_wdata = '0;
    fill_we   = 1'b0;
    miss_done = 1'b0;
    unique case (state_q)
      EVICT: begin
        dfp_write = 1'b1;
        dfp_addr  = {vtag_q, set_q, 5'b0};
        dfp_wdata = evict_data;
      end
      FILL: begin
        dfp_read = 1'b1;
        dfp_addr = {tag_q, set_q, 5'b0};
      end
      WRITE:   fill_we   = 1'b1;
      DONE:    miss_done = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign fill_set  = busy ? set_q : 4'd0;
  assign fill_way  = busy ? way_q : 2'd0;
  assign fill_tag  = tag_q;
  assign fill_data = line_q;

  // Capture the miss context and the returned line.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= '0;
      vtag_q <= '0;
      set_q  <= '0;
      way_q  <= '0;
      line_q <= '0;
    end else begin
      if (accept) begin
        tag_q  <= miss_addr[31:9];
        set_q  <= req_set;
        way_q  <= victim;
        vtag_q <= tags_in[victim];
      end
      if (state_q == FILL && dfp_resp) line_q <= dfp_rdata;
    end
  end

  assign fill_upd = (state_q == WRITE);
  assign hit_ok   = hit_update && !(fill_upd && hit_set == set_q);

  // PLRU tree per set; the fill wins over a hit on the same set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) plru_q[i] <= '0;
    end else begin
      if (hit_ok)   plru_q[hit_set] <= plru_touch(plru_q[hit_set], hit_way);
      if (fill_upd) plru_q[set_q]   <= plru_touch(plru_q[set_q], way_q);
    end
  end

endmodule
